pipe_stage_skid: RTL

//   Parametrised valid/ready pipeline register; successor to the fixed IF/ID latch. Replaces the global

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_sat_cnt.sv | 19 +
 rtl/pipe_stage_skid.sv | 89 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the core pipeline stage registers: NOP encoding,
// per-stage payload layouts and the default perf counter width.
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;
    localparam int          PIPE_CNT_W     = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } id_ex_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr_i wins over inc_i.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry (main + skid) buffer and flush.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic              main_vld_p1;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] main_data_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              in_fire;
    logic              out_fire;

    // Ready comes straight from the skid flop, so out_ready_i never reaches it combinationally.
    assign in_ready_o  = !skid_vld_p1;
    assign out_valid_o = main_vld_p1;
    assign out_data_o  = main_data_p1;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = main_vld_p1 && out_ready_i;

    // ---- stage p1: main/skid registers ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            main_data_p1 <= FLUSH_VAL;
            skid_data_p1 <= FLUSH_VAL;
        end else if (flush_i) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            main_data_p1 <= FLUSH_VAL;
        end else if (skid_vld_p1 && out_fire) begin
            // in_ready_o is low here, so no new input can collide with the drain.
            main_data_p1 <= skid_data_p1;
            skid_vld_p1  <= 1'b0;
        end else if (!main_vld_p1 || out_fire) begin
            main_vld_p1 <= in_fire;
            if (in_fire) begin
                main_data_p1 <= in_data_i;
            end
        end else if (in_fire) begin
            skid_data_p1 <= in_data_i;
            skid_vld_p1  <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // skid_vld implies main_vld, so main_vld alone tells whether a flush kills anything.
    assign stall_inc = main_vld_p1 && !out_ready_i;
    assign flush_inc = flush_i && main_vld_p1;

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .inc_i (stall_inc),
        .clr_i (rst_i),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .inc_i (flush_inc),
        .clr_i (rst_i),
        .cnt_o (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
